timer_counter: RTL and testbench

- Memory-mapped timer/counter peripheral. Acts as the responder on the system bridge device bus, in the TC window 0x7f00–0x7f0b.
- Receives the bridge's pass-through address, write data and a single write-enable.
- Returns read data combinationally. The bridge registers this data, so read latency is 1 cycle as seen by the CPU.
- Counts down from a programmed preset and raises an interrupt request toward the CPU's external-interrupt input.

---
 rtl/timer_counter_if.sv | 12 +
 rtl/timer_counter.sv | 115 +++++++++++
 tb/tb_timer_counter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// Device-bus bundle between the system bridge and the timer/counter responder.
// Bridge drives address/write data/write enable; the timer returns read data and its irq level.
interface timer_counter_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, output we, output wdata, input rdata, input irq);
    modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_counter.sv
// Down-counting timer/counter peripheral: CTRL/PRESET/COUNT registers, one-shot or auto-reload, masked level irq.
// Register writes land at the clock edge; reads are combinational (the bridge adds the one cycle of read latency); no backpressure.
module timer_counter #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic        w_reload_mode;
    logic        w_expire;
    logic        w_int_clear;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    assign w_wr_ctrl     = bus.we && (bus.addr[3:2] == 2'd0);
    assign w_wr_preset   = bus.we && (bus.addr[3:2] == 2'd1);
    assign w_en          = r_ctrl[0];
    assign w_reload_mode = (r_ctrl[2:1] == 2'b01);
    // Terminal count: the CNT cycle that moves COUNT to 0 and raises the flag.
    assign w_expire      = (r_state == S_CNT) && w_en && (r_count <= 32'd1);
    assign w_int_clear   = (r_state == S_INT) && w_reload_mode;
    assign w_unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 4'h0;
            r_preset   <= PRESET_RST;
            r_count    <= 32'h0;
            r_irq_flag <= 1'b0;
        end else begin
            // A CPU write to CTRL takes priority over the one-shot EN auto-clear.
            if (w_wr_ctrl) begin
                r_ctrl <= bus.wdata[3:0];
            end else if (w_expire && !w_reload_mode) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_wr_preset) begin
                r_preset <= bus.wdata;
            end

            // Setting beats clearing so an expiry coinciding with a CPU write is never lost.
            if (w_expire) begin
                r_irq_flag <= 1'b1;
            end else if (w_wr_ctrl || w_wr_preset || w_int_clear) begin
                r_irq_flag <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_en) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!w_en) begin
                        r_state <= S_IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count <= 32'h0;
                        r_state <= S_INT;
                    end
                end
                S_INT: begin
                    if (w_reload_mode && w_en) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        case (bus.addr[3:2])
            2'd0:    w_rdata = {28'h0, r_ctrl};
            2'd1:    w_rdata = r_preset;
            2'd2:    w_rdata = r_count;
            default: w_rdata = 32'h0;
        endcase
    end

    assign bus.rdata = w_rdata;
    assign bus.irq   = r_irq_flag & r_ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus random register traffic,
// compared every cycle against a phase/age reference model of the timer.
module tb_timer_counter;

    localparam logic [31:0] P_RST = 32'h0000_0007;

    logic clk;
    logic reset;

    timer_counter_if bus ();

    timer_counter #(.PRESET_RST(P_RST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: timer described by "running" plus age since the last reload.
    // age 0 = loading, 1..n = counting, n+1 = expired/interrupt cycle.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic [31:0] m_n;
    bit          m_flag;
    bit          m_run;
    int unsigned m_age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl   = 4'h0;
        m_preset = P_RST;
        m_count  = 32'h0;
        m_n      = 32'h1;
        m_flag   = 1'b0;
        m_run    = 1'b0;
        m_age    = 0;
    endtask

    task automatic model_edge(input bit w, input logic [1:0] off, input logic [31:0] d);
        bit          en;
        bit          rel;
        bit          set_f;
        bit          clr_f;
        logic [3:0]  ctrl_n;
        logic [31:0] preset_n;
        logic [31:0] count_n;
        logic [31:0] n_n;
        bit          run_n;
        int unsigned age_n;
        en       = m_ctrl[0];
        rel      = (m_ctrl[2:1] == 2'd1);
        set_f    = 1'b0;
        clr_f    = 1'b0;
        ctrl_n   = m_ctrl;
        preset_n = m_preset;
        count_n  = m_count;
        n_n      = m_n;
        run_n    = m_run;
        age_n    = m_age;
        if (!m_run) begin
            if (en) begin
                run_n = 1'b1;
                age_n = 0;
            end
        end else if (m_age == 0) begin
            count_n = m_preset;
            n_n     = (m_preset == 32'h0) ? 32'h1 : m_preset;
            age_n   = 1;
        end else if (m_age <= m_n) begin
            if (!en) begin
                run_n = 1'b0;
            end else begin
                age_n   = m_age + 1;
                count_n = m_n - m_age;
                if (m_age == m_n) begin
                    set_f = 1'b1;
                    if (!rel) ctrl_n[0] = 1'b0;
                end
            end
        end else begin
            if (rel) begin
                clr_f = 1'b1;
                if (en) age_n = 0;
                else    run_n = 1'b0;
            end else begin
                run_n = 1'b0;
            end
        end
        if (w && off == 2'd0) begin
            ctrl_n = d[3:0];
            clr_f  = 1'b1;
        end
        if (w && off == 2'd1) begin
            preset_n = d;
            clr_f    = 1'b1;
        end
        if (set_f)      m_flag = 1'b1;
        else if (clr_f) m_flag = 1'b0;
        m_ctrl   = ctrl_n;
        m_preset = preset_n;
        m_count  = count_n;
        m_n      = n_n;
        m_run    = run_n;
        m_age    = age_n;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] v);
        bus.we   = 1'b0;
        bus.addr = 32'h0000_7f00 + {28'h0, off, 2'b00};
        #1;
        v = bus.rdata;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        rd(2'd0, v); chk({tag, ".ctrl"},   v, {28'h0, m_ctrl});
        rd(2'd1, v); chk({tag, ".preset"}, v, m_preset);
        rd(2'd2, v); chk({tag, ".count"},  v, m_count);
        rd(2'd3, v); chk({tag, ".rsvd"},   v, 32'h0);
        chk({tag, ".irq"}, {31'h0, bus.irq}, {31'h0, m_flag & m_ctrl[3]});
    endtask

    task automatic tick(input string tag, input bit w, input logic [1:0] off, input logic [31:0] d);
        bus.we    = w;
        bus.addr  = 32'h0000_7f00 + {28'h0, off, 2'b00};
        bus.wdata = d;
        @(posedge clk);
        model_edge(w, off, d);
        #1;
        bus.we = 1'b0;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        logic [31:0] v;
        reset = 1'b0;
        model_reset();
        rd(2'd0, v); chk({tag, ".ctrl0"},   v, 32'h0);
        rd(2'd1, v); chk({tag, ".preset0"}, v, P_RST);
        rd(2'd2, v); chk({tag, ".count0"},  v, 32'h0);
        chk({tag, ".irq0"}, {31'h0, bus.irq}, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] v;
        int          last;
        int          npulse;
        bit          found;
        reset     = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        model_reset();
        #6;
        check_all("reset");
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;

        // One-shot, PRESET=5
        tick("os_pre", 1'b1, 2'd1, 32'd5);
        tick("os_en",  1'b1, 2'd0, 32'h9);
        for (int i = 1; i <= 7; i++) begin
            tick("os_run", 1'b0, 2'd0, 32'h0);
            if (i == 2) begin rd(2'd2, v); chk("os_cnt_e2", v, 32'd5); end
            if (i == 6) begin rd(2'd2, v); chk("os_cnt_e6", v, 32'd1); end
        end
        rd(2'd2, v); chk("os_cnt_e7", v, 32'd0);
        rd(2'd0, v); chk("os_ctrl_e7", v, 32'h8);
        chk("os_irq_e7", {31'h0, bus.irq}, 32'h1);
        for (int i = 0; i < 20; i++) tick("os_hold", 1'b0, 2'd0, 32'h0);
        chk("os_irq_held", {31'h0, bus.irq}, 32'h1);
        tick("os_clr", 1'b1, 2'd0, 32'h8);
        chk("os_irq_cleared", {31'h0, bus.irq}, 32'h0);

        // Auto-reload, PRESET=3: pulses every 5 cycles
        tick("ar_pre", 1'b1, 2'd1, 32'd3);
        tick("ar_en",  1'b1, 2'd0, 32'hB);
        last   = -1;
        npulse = 0;
        for (int i = 1; i <= 30; i++) begin
            tick("ar_run", 1'b0, 2'd0, 32'h0);
            if (bus.irq) begin
                if (last >= 0) chk("ar_gap", i - last, 32'd5);
                last = i;
                npulse++;
            end
        end
        chk("ar_pulses_ge4", {31'h0, npulse >= 4}, 32'h1);
        tick("ar_stop", 1'b1, 2'd0, 32'h0);
        for (int i = 0; i < 3; i++) tick("ar_idle", 1'b0, 2'd0, 32'h0);

        // Masked expiry, then a write that clears the pending flag
        tick("mk_pre", 1'b1, 2'd1, 32'd2);
        tick("mk_en",  1'b1, 2'd0, 32'h1);
        for (int i = 0; i < 6; i++) tick("mk_run", 1'b0, 2'd0, 32'h0);
        rd(2'd2, v); chk("mk_cnt0", v, 32'd0);
        chk("mk_irq0", {31'h0, bus.irq}, 32'h0);
        tick("mk_im", 1'b1, 2'd0, 32'h8);
        for (int i = 0; i < 3; i++) tick("mk_after", 1'b0, 2'd0, 32'h0);
        chk("mk_irq_after", {31'h0, bus.irq}, 32'h0);

        // Pause mid-count, then re-enable reloads from the new PRESET
        tick("pz_pre", 1'b1, 2'd1, 32'd10);
        tick("pz_en",  1'b1, 2'd0, 32'h9);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_run && m_age >= 1 && m_count == 32'd7) found = 1'b1;
            else tick("pz_run", 1'b0, 2'd0, 32'h0);
        end
        chk("pz_reach7", {31'h0, found}, 32'h1);
        tick("pz_dis", 1'b1, 2'd0, 32'h8);
        for (int i = 0; i < 6; i++) tick("pz_hold", 1'b0, 2'd0, 32'h0);
        rd(2'd2, v); chk("pz_held6", v, 32'd6);
        tick("pz_pre4", 1'b1, 2'd1, 32'd4);
        tick("pz_ren",  1'b1, 2'd0, 32'h9);
        tick("pz_r1", 1'b0, 2'd0, 32'h0);
        tick("pz_r2", 1'b0, 2'd0, 32'h0);
        rd(2'd2, v); chk("pz_reload4", v, 32'd4);
        for (int i = 0; i < 6; i++) tick("pz_fin", 1'b0, 2'd0, 32'h0);

        // Decode: COUNT and reserved slots ignore writes; CTRL keeps only [3:0]
        tick("dc_w8", 1'b1, 2'd2, 32'hFFFF_FFFF);
        tick("dc_wc", 1'b1, 2'd3, 32'hFFFF_FFFF);
        rd(2'd3, v); chk("dc_rsvd", v, 32'h0);
        tick("dc_ctrl", 1'b1, 2'd0, 32'hFFFF_FFF0);
        rd(2'd0, v); chk("dc_ctrl0", v, 32'h0);

        // Async reset with COUNT=3 mid-count
        tick("rs_pre", 1'b1, 2'd1, 32'd5);
        tick("rs_en",  1'b1, 2'd0, 32'h9);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_run && m_age >= 1 && m_count == 32'd3) found = 1'b1;
            else tick("rs_run", 1'b0, 2'd0, 32'h0);
        end
        chk("rs_reach3", {31'h0, found}, 32'h1);
        async_reset("rs_mid");

        // Async reset while irq is asserted drops it immediately
        tick("ri_pre", 1'b1, 2'd1, 32'd1);
        tick("ri_en",  1'b1, 2'd0, 32'h9);
        for (int i = 0; i < 3; i++) tick("ri_run", 1'b0, 2'd0, 32'h0);
        chk("ri_irq_up", {31'h0, bus.irq}, 32'h1);
        async_reset("ri");

        // Random register traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit          w;
            logic [1:0]  off;
            logic [31:0] d;
            w   = ($urandom_range(0, 3) == 0);
            off = 2'($urandom_range(0, 3));
            case (off)
                2'd0:    d = {$urandom_range(0, 1) == 0 ? 28'h0 : 28'($urandom), 4'($urandom_range(0, 15))};
                2'd1:    d = 32'($urandom_range(0, 6));
                default: d = $urandom;
            endcase
            tick("rnd", w, off, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
